usb_rx_rcu: RTL and testbench



---
 rtl/usb_rx_rcu_pkg.sv | 20 ++
 rtl/usb_rx_rcu_if.sv | 26 ++
 rtl/usb_rx_rcu.sv | 129 ++++++++++++
 tb/tb_usb_rx_rcu.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_rcu_pkg.sv
// Shared types and defaults for the USB full-speed receive control unit.
package usb_rx_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    SYNC_RCV = 4'd1,
    SYNC_CHK = 4'd2,
    DATA_RCV = 4'd3,
    STORE    = 4'd4,
    EOP_WAIT = 4'd5,
    ERR_EOP  = 4'd6,
    ERR_WAIT = 4'd7,
    EIDLE    = 4'd8
  } rcu_state_t;

  // Decoded sync pattern: the wire sends 0000_0001 LSB-first.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h80;
  localparam int         CNT_W_DEFAULT     = 8;

endpackage

// File: rtl/usb_rx_rcu_if.sv
// Signal bundle between the bit timer / shift register side and the receive control unit.
interface usb_rx_rcu_if #(
  parameter int CNT_W = 8
);

  logic             d_edge;
  logic             eop;
  logic             shift_enable;
  logic             byte_received;
  logic [7:0]       rcv_data;
  logic             rcving;
  logic             w_enable;
  logic             r_error;
  logic [CNT_W-1:0] byte_count;

  modport master (
    output d_edge, eop, shift_enable, byte_received, rcv_data,
    input  rcving, w_enable, r_error, byte_count
  );

  modport slave (
    input  d_edge, eop, shift_enable, byte_received, rcv_data,
    output rcving, w_enable, r_error, byte_count
  );

endinterface

// File: rtl/usb_rx_rcu.sv
// Receive control unit: frames packets, checks sync, strobes FIFO writes and flags framing errors.
module usb_rx_rcu
  import usb_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         CNT_W     = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  usb_rx_rcu_if.slave  bus
);

  rcu_state_t       state_q;
  rcu_state_t       state_d;
  logic [2:0]       bit_cnt_q;
  logic [CNT_W-1:0] byte_count_q;

  logic rcving;
  logic w_enable;
  logic r_error;
  logic eop_sample;
  logic enter_sync;

  assign eop_sample = bus.eop & bus.shift_enable;
  assign enter_sync = (state_d == SYNC_RCV) && (state_q != SYNC_RCV);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.d_edge) state_d = SYNC_RCV;
      end
      SYNC_RCV: begin
        if (bus.byte_received)   state_d = SYNC_CHK;
        else if (eop_sample)     state_d = ERR_WAIT;
      end
      SYNC_CHK: begin
        if (bus.rcv_data == SYNC_BYTE) state_d = DATA_RCV;
        else                           state_d = ERR_EOP;
      end
      DATA_RCV: begin
        // A completed byte wins over an EOP seen in the same cycle.
        if (bus.byte_received)                    state_d = STORE;
        else if (eop_sample && bit_cnt_q == 3'd0) state_d = EOP_WAIT;
        else if (eop_sample)                      state_d = ERR_WAIT;
      end
      STORE: begin
        state_d = DATA_RCV;
      end
      EOP_WAIT: begin
        if (bus.d_edge) state_d = IDLE;
      end
      ERR_EOP: begin
        if (eop_sample) state_d = ERR_WAIT;
      end
      ERR_WAIT: begin
        if (bus.d_edge) state_d = EIDLE;
      end
      EIDLE: begin
        if (bus.d_edge) state_d = SYNC_RCV;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rcving   = 1'b0;
    w_enable = 1'b0;
    r_error  = 1'b0;
    case (state_q)
      SYNC_RCV, SYNC_CHK, DATA_RCV, EOP_WAIT: begin
        rcving = 1'b1;
      end
      STORE: begin
        rcving   = 1'b1;
        w_enable = 1'b1;
      end
      ERR_EOP, ERR_WAIT: begin
        rcving  = 1'b1;
        r_error = 1'b1;
      end
      EIDLE: begin
        r_error = 1'b1;
      end
      default: begin
        rcving   = 1'b0;
        w_enable = 1'b0;
        r_error  = 1'b0;
      end
    endcase
  end

  // Bit position within the current byte; used to tell a clean EOP from one mid-byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= 3'd0;
    end else if (bus.byte_received || enter_sync) begin
      bit_cnt_q <= 3'd0;
    end else if (bus.shift_enable && rcving) begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_count_q <= '0;
    end else if (enter_sync) begin
      byte_count_q <= '0;
    end else if (state_q == STORE && byte_count_q != {CNT_W{1'b1}}) begin
      byte_count_q <= byte_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.rcving     = rcving;
  assign bus.w_enable   = w_enable;
  assign bus.r_error    = r_error;
  assign bus.byte_count = byte_count_q;

endmodule

// File: tb/tb_usb_rx_rcu.sv
// Directed self-checking bench for usb_rx_rcu: good packet, bad sync, early EOP, recovery, saturation, reset.
module tb_usb_rx_rcu;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   w_count;
  int   w_base;

  usb_rx_rcu_if #(.CNT_W(8)) bus ();

  usb_rx_rcu #(
    .SYNC_BYTE (8'h80),
    .CNT_W     (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent tally of FIFO write strobes, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.w_enable === 1'b1) w_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_edge();
    bus.d_edge = 1'b1;
    tick();
    bus.d_edge = 1'b0;
  endtask

  task automatic shift_bits(input int n);
    for (int i = 0; i < n; i++) begin
      bus.shift_enable = 1'b1;
      tick();
      bus.shift_enable = 1'b0;
      tick();
    end
  endtask

  task automatic eop_at_bit_centre();
    bus.eop          = 1'b1;
    bus.shift_enable = 1'b1;
    tick();
    bus.shift_enable = 1'b0;
    bus.eop          = 1'b0;
  endtask

  // Eight bit strobes, then byte_received the following cycle; optionally an EOP strobe rides along.
  task automatic send_byte(input logic [7:0] b, input logic with_eop);
    for (int i = 0; i < 8; i++) begin
      bus.shift_enable = 1'b1;
      tick();
      bus.shift_enable = 1'b0;
      if (i != 7) tick();
    end
    bus.byte_received = 1'b1;
    bus.rcv_data      = b;
    if (with_eop) begin
      bus.eop          = 1'b1;
      bus.shift_enable = 1'b1;
    end
    tick();
    bus.byte_received = 1'b0;
    bus.eop           = 1'b0;
    bus.shift_enable  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    w_count  = 0;
    bus.d_edge        = 1'b0;
    bus.eop           = 1'b0;
    bus.shift_enable  = 1'b0;
    bus.byte_received = 1'b0;
    bus.rcv_data      = 8'h00;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("init_rcving", bus.rcving, 0);
    check("init_w_enable", bus.w_enable, 0);
    check("init_r_error", bus.r_error, 0);
    check("init_byte_count", bus.byte_count, 0);

    $display("[TB] good packet");
    pulse_edge();
    check("good_rcving_start", bus.rcving, 1);
    send_byte(8'h80, 1'b0);
    check("good_sync_chk_r_error", bus.r_error, 0);
    tick();
    check("good_data_r_error", bus.r_error, 0);
    pulse_edge();
    check("good_edge_ignored_rcving", bus.rcving, 1);
    check("good_edge_ignored_r_error", bus.r_error, 0);
    send_byte(8'hA5, 1'b0);
    check("good_w1_pulse", bus.w_enable, 1);
    tick();
    check("good_w1_end", bus.w_enable, 0);
    check("good_count1", bus.byte_count, 1);
    bus.eop = 1'b1;
    tick();
    bus.eop = 1'b0;
    check("good_eop_no_strobe_rcving", bus.rcving, 1);
    check("good_eop_no_strobe_r_error", bus.r_error, 0);
    send_byte(8'h3C, 1'b0);
    check("good_w2_pulse", bus.w_enable, 1);
    tick();
    check("good_w2_end", bus.w_enable, 0);
    check("good_count2", bus.byte_count, 2);
    eop_at_bit_centre();
    check("good_eop_wait_rcving", bus.rcving, 1);
    check("good_eop_wait_r_error", bus.r_error, 0);
    pulse_edge();
    check("good_end_rcving", bus.rcving, 0);
    check("good_end_r_error", bus.r_error, 0);
    check("good_end_count", bus.byte_count, 2);
    check("good_w_total", w_count, 2);

    $display("[TB] bad sync");
    pulse_edge();
    check("bad_count_cleared", bus.byte_count, 0);
    send_byte(8'h81, 1'b0);
    check("bad_sync_chk_r_error", bus.r_error, 0);
    tick();
    check("bad_err_r_error", bus.r_error, 1);
    check("bad_err_rcving", bus.rcving, 1);
    pulse_edge();
    check("bad_edge_ignored_rcving", bus.rcving, 1);
    bus.eop = 1'b1;
    tick();
    bus.shift_enable = 1'b1;
    tick();
    bus.shift_enable = 1'b0;
    bus.eop = 1'b0;
    check("bad_err_wait_rcving", bus.rcving, 1);
    pulse_edge();
    check("bad_eidle_rcving", bus.rcving, 0);
    check("bad_eidle_r_error", bus.r_error, 1);
    tick();
    check("bad_eidle_sticky", bus.r_error, 1);
    check("bad_no_writes", w_count, 2);

    $display("[TB] recovery and early EOP");
    pulse_edge();
    check("rec_r_error_clear", bus.r_error, 0);
    check("rec_rcving", bus.rcving, 1);
    send_byte(8'h80, 1'b0);
    tick();
    send_byte(8'h5A, 1'b1);
    check("rec_byte_beats_eop", bus.w_enable, 1);
    tick();
    check("rec_count1", bus.byte_count, 1);
    shift_bits(3);
    eop_at_bit_centre();
    check("early_r_error", bus.r_error, 1);
    check("early_rcving", bus.rcving, 1);
    check("early_count", bus.byte_count, 1);
    tick();
    tick();
    check("early_no_more_writes", w_count, 3);
    pulse_edge();
    check("early_eidle_rcving", bus.rcving, 0);
    check("early_eidle_count_hold", bus.byte_count, 1);
    pulse_edge();
    check("rec2_r_error_clear", bus.r_error, 0);
    check("rec2_count_cleared", bus.byte_count, 0);

    $display("[TB] saturation");
    send_byte(8'h80, 1'b0);
    tick();
    w_base = w_count;
    for (int i = 0; i < 260; i++) begin
      send_byte(i[7:0], 1'b0);
      tick();
      if (i == 253) check("sat_count_254", bus.byte_count, 8'hFE);
      if (i == 254) check("sat_count_255", bus.byte_count, 8'hFF);
    end
    check("sat_count_hold", bus.byte_count, 8'hFF);
    check("sat_writes", w_count - w_base, 260);

    $display("[TB] reset mid-packet");
    shift_bits(2);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_rcving", bus.rcving, 0);
    check("rst_w_enable", bus.w_enable, 0);
    check("rst_r_error", bus.r_error, 0);
    check("rst_byte_count", bus.byte_count, 0);
    tick();
    check("rst_idle_holds", bus.rcving, 0);
    pulse_edge();
    check("rst_then_start", bus.rcving, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
